// File: rtl/bpu_nextpc_pkg.sv
// Shared constants for the IF-stage next-PC unit: instruction/PC widths,
// RV32 opcodes and register numbers used by predecode, and the next-PC source enum.
package bpu_nextpc_pkg;

   localparam int INSTR_SIZE = 32;
   localparam int PC_SIZE    = 32;

   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_B_TYPE = 7'b1100011;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd1;
   localparam logic [4:0] REG_T0   = 5'd5;

   localparam logic [1:0] CTR_RESET = 2'b01;

   typedef enum logic [2:0] {
      NPC_FAIL,
      NPC_JALR,
      NPC_HOLD,
      NPC_JAL,
      NPC_BXX,
      NPC_RAS,
      NPC_SEQ
   } npc_src_e;

   // Link registers per the RISC-V calling convention: ra and the alternate link t0.
   function automatic logic is_link_reg(input logic [4:0] r);
      return (r == REG_RA) || (r == REG_T0);
   endfunction

endpackage

// File: rtl/bpu_bht.sv
// Branch history table: one 2-bit saturating counter per entry.
// Combinational read of the prediction bit, synchronous saturating update.
// A read and an update of the same entry in one cycle return the old value.
module bpu_bht
   import bpu_nextpc_pkg::*;
#(
   parameter int BHT_ENTRY = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [$clog2(BHT_ENTRY)-1:0] rd_idx,
   output logic                         rd_taken,
   input  logic                         upd_valid,
   input  logic [$clog2(BHT_ENTRY)-1:0] upd_idx,
   input  logic                         upd_taken
);

   logic [1:0] ctr_q [BHT_ENTRY];
   logic [1:0] ctr_d [BHT_ENTRY];

   assign rd_taken = ctr_q[rd_idx][1];

   // Saturating increment on taken, decrement on not-taken, only for the resolved entry.
   always_comb begin
      ctr_d = ctr_q;
      if (upd_valid) begin
         if (upd_taken) begin
            if (ctr_q[upd_idx] != 2'b11) begin
               ctr_d[upd_idx] = ctr_q[upd_idx] + 2'b01;
            end
         end else begin
            if (ctr_q[upd_idx] != 2'b00) begin
               ctr_d[upd_idx] = ctr_q[upd_idx] - 2'b01;
            end
         end
      end
   end

   // Counter storage, all entries start weakly not-taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRY; i++) begin
            ctr_q[i] <= CTR_RESET;
         end
      end else begin
         ctr_q <= ctr_d;
      end
   end

endmodule

// File: rtl/bpu_nextpc.sv
// Next-PC unit for the IF stage: owns the PC, predecodes the fetched instruction,
// predicts conditional branches with the BHT and returns with a circular RAS,
// and applies redirects from ID (jalr) and EX (branch mispredict).
module bpu_nextpc
   import bpu_nextpc_pkg::*;
#(
   parameter logic [PC_SIZE-1:0] RESET_PC  = 32'h0000_0000,
   parameter int                 BHT_ENTRY = 64,
   parameter bit                 BHT_EN    = 1'b1,
   parameter int                 RAS_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INSTR_SIZE-1:0] instr,
   input  logic                  stall,
   output logic [PC_SIZE-1:0]    pc,
   output logic                  take,
   output logic                  ras_used,
   output logic                  instr_nop_sel,
   input  logic                  id_jalr,
   input  logic [PC_SIZE-1:0]    id_reg_value,
   input  logic                  predict_fail,
   input  logic [PC_SIZE-1:0]    bxx_fail_pc,
   input  logic                  res_valid,
   input  logic [PC_SIZE-1:0]    res_pc,
   input  logic                  res_taken
);

   localparam int IDX_W  = $clog2(BHT_ENTRY);
   localparam bit RAS_ON = (RAS_DEPTH > 0);
   localparam int RAS_N  = RAS_ON ? RAS_DEPTH : 2;
   localparam int RAS_PW = $clog2(RAS_N);
   localparam int CNT_W  = $clog2(RAS_N + 1);
   localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_N);

   logic [PC_SIZE-1:0] pc_q, pc_d;
   logic [PC_SIZE-1:0] ras_q [RAS_N];
   logic [PC_SIZE-1:0] ras_d [RAS_N];
   logic [RAS_PW-1:0]  ras_ptr_q, ras_ptr_d;
   logic [CNT_W-1:0]   ras_cnt_q, ras_cnt_d;

   logic [6:0]         opcode;
   logic [4:0]         rd;
   logic [4:0]         rs1;
   logic               is_jal, is_bxx, is_ret, is_call;
   logic [PC_SIZE-1:0] j_imm, b_imm, pc_plus4, ras_top;
   logic               bht_taken, ras_avail;
   npc_src_e           npc_src;
   logic               unused_res_pc;

   assign opcode  = instr[6:0];
   assign rd      = instr[11:7];
   assign rs1     = instr[19:15];
   assign is_jal  = (opcode == OPCODE_JAL);
   assign is_bxx  = (opcode == OPCODE_B_TYPE);
   assign is_ret  = (opcode == OPCODE_JALR) && (rd == REG_ZERO) && is_link_reg(rs1);
   assign is_call = is_jal && is_link_reg(rd);

   assign j_imm = {{(PC_SIZE-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign b_imm = {{(PC_SIZE-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

   assign pc_plus4  = pc_q + PC_SIZE'(4);
   assign ras_top   = ras_q[ras_ptr_q - RAS_PW'(1)];
   assign ras_avail = RAS_ON && (ras_cnt_q != '0);

   assign unused_res_pc = ^{res_pc[1:0], res_pc[PC_SIZE-1:IDX_W+2]};

   bpu_bht #(
      .BHT_ENTRY (BHT_ENTRY)
   ) u_bht (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (pc_q[IDX_W+1:2]),
      .rd_taken  (bht_taken),
      .upd_valid (res_valid),
      .upd_idx   (res_pc[IDX_W+1:2]),
      .upd_taken (res_taken)
   );

   assign take          = is_bxx && (BHT_EN ? bht_taken : instr[31]);
   assign pc            = pc_q;
   assign ras_used      = (npc_src == NPC_RAS);
   assign instr_nop_sel = predict_fail | id_jalr;

   // Pick exactly one next-PC source, redirects first, then stall, then predictions.
   always_comb begin
      npc_src = NPC_SEQ;
      if (predict_fail) begin
         npc_src = NPC_FAIL;
      end else if (id_jalr) begin
         npc_src = NPC_JALR;
      end else if (stall) begin
         npc_src = NPC_HOLD;
      end else if (is_jal) begin
         npc_src = NPC_JAL;
      end else if (take) begin
         npc_src = NPC_BXX;
      end else if (is_ret && ras_avail) begin
         npc_src = NPC_RAS;
      end
   end

   // Next-PC mux driven by the selected source; adders wrap naturally.
   always_comb begin
      pc_d = pc_plus4;
      case (npc_src)
         NPC_FAIL: pc_d = bxx_fail_pc;
         NPC_JALR: pc_d = id_reg_value;
         NPC_HOLD: pc_d = pc_q;
         NPC_JAL:  pc_d = pc_q + j_imm;
         NPC_BXX:  pc_d = pc_q + b_imm;
         NPC_RAS:  pc_d = ras_top;
         default:  pc_d = pc_plus4;
      endcase
   end

   // RAS push on a predicted call, pop on a predicted return; a full push overwrites the oldest.
   always_comb begin
      ras_d     = ras_q;
      ras_ptr_d = ras_ptr_q;
      ras_cnt_d = ras_cnt_q;
      if (RAS_ON && (npc_src == NPC_JAL) && is_call) begin
         ras_d[ras_ptr_q] = pc_plus4;
         ras_ptr_d        = ras_ptr_q + RAS_PW'(1);
         if (ras_cnt_q != RAS_FULL) begin
            ras_cnt_d = ras_cnt_q + CNT_W'(1);
         end
      end else if (npc_src == NPC_RAS) begin
         ras_ptr_d = ras_ptr_q - RAS_PW'(1);
         ras_cnt_d = ras_cnt_q - CNT_W'(1);
      end
   end

   // PC and RAS state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         ras_ptr_q <= '0;
         ras_cnt_q <= '0;
         for (int i = 0; i < RAS_N; i++) begin
            ras_q[i] <= '0;
         end
      end else begin
         pc_q      <= pc_d;
         ras_ptr_q <= ras_ptr_d;
         ras_cnt_q <= ras_cnt_d;
         ras_q     <= ras_d;
      end
   end

endmodule

// File: tb/tb_bpu_nextpc.sv
// Directed bench for bpu_nextpc. Each stimulus cycle pushes its hand-computed
// expected outputs into a scoreboard; a monitor on the falling edge pops and compares.
module tb_bpu_nextpc;

   localparam logic [31:0] I_NOP    = 32'h0000_0013;
   localparam logic [31:0] I_BEQ_M8 = 32'hFE00_0CE3;
   localparam logic [31:0] I_BEQ_16 = 32'h0000_0863;
   localparam logic [31:0] I_JAL_RA = 32'h1000_00EF;
   localparam logic [31:0] I_RET    = 32'h0000_8067;

   typedef struct packed {
      logic [31:0] pc;
      logic        take;
      logic        ras_used;
      logic        nop_sel;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        stall;
   logic [31:0] pc;
   logic        take;
   logic        ras_used;
   logic        instr_nop_sel;
   logic        id_jalr;
   logic [31:0] id_reg_value;
   logic        predict_fail;
   logic [31:0] bxx_fail_pc;
   logic        res_valid;
   logic [31:0] res_pc;
   logic        res_taken;

   exp_t  expQ[$];
   string nameQ[$];
   int    checks = 0;
   int    passed = 0;

   bpu_nextpc #(
      .RESET_PC  (32'h0000_0000),
      .BHT_ENTRY (64),
      .BHT_EN    (1'b1),
      .RAS_DEPTH (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .instr         (instr),
      .stall         (stall),
      .pc            (pc),
      .take          (take),
      .ras_used      (ras_used),
      .instr_nop_sel (instr_nop_sel),
      .id_jalr       (id_jalr),
      .id_reg_value  (id_reg_value),
      .predict_fail  (predict_fail),
      .bxx_fail_pc   (bxx_fail_pc),
      .res_valid     (res_valid),
      .res_pc        (res_pc),
      .res_taken     (res_taken)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   task automatic clearInputs();
      rst          = 1'b0;
      instr        = I_NOP;
      stall        = 1'b0;
      id_jalr      = 1'b0;
      id_reg_value = 32'h0;
      predict_fail = 1'b0;
      bxx_fail_pc  = 32'h0;
      res_valid    = 1'b0;
      res_pc       = 32'h0;
      res_taken    = 1'b0;
   endtask

   task automatic setFail(input logic [31:0] target);
      predict_fail = 1'b1;
      bxx_fail_pc  = target;
   endtask

   task automatic setResolve(input logic [31:0] rpc, input logic taken);
      res_valid = 1'b1;
      res_pc    = rpc;
      res_taken = taken;
   endtask

   task automatic applyStimulus(input string name, input logic [31:0] ePc,
                                input logic eTake, input logic eRas, input logic eNop);
      exp_t e;
      e.pc       = ePc;
      e.take     = eTake;
      e.ras_used = eRas;
      e.nop_sel  = eNop;
      expQ.push_back(e);
      nameQ.push_back(name);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input exp_t e);
      checks++;
      if (pc === e.pc) passed++;
      else $display("[TB] FAIL %s.pc actual=%h required=%h", name, pc, e.pc);
      checks++;
      if (take === e.take) passed++;
      else $display("[TB] FAIL %s.take actual=%b required=%b", name, take, e.take);
      checks++;
      if (ras_used === e.ras_used) passed++;
      else $display("[TB] FAIL %s.ras_used actual=%b required=%b", name, ras_used, e.ras_used);
      checks++;
      if (instr_nop_sel === e.nop_sel) passed++;
      else $display("[TB] FAIL %s.instr_nop_sel actual=%b required=%b", name, instr_nop_sel, e.nop_sel);
   endtask

   // Monitor: whenever an expectation is pending, compare the DUT outputs mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            checkOutput(nameQ.pop_front(), expQ.pop_front());
         end
      end
   end

   // Directed stimulus with expected pc/take/ras_used/instr_nop_sel for each cycle.
   initial begin
      clearInputs();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;

      clearInputs(); instr = I_BEQ_M8;
      applyStimulus("reset_pc_take0", 32'h0000_0000, 1'b0, 1'b0, 1'b0);
      clearInputs(); setResolve(32'h40, 1'b1);
      applyStimulus("train_t1", 32'h0000_0004, 1'b0, 1'b0, 1'b0);
      clearInputs(); setResolve(32'h40, 1'b1);
      applyStimulus("train_t2", 32'h0000_0008, 1'b0, 1'b0, 1'b0);
      clearInputs(); setResolve(32'h40, 1'b1); setFail(32'h40);
      applyStimulus("train_t3_sat_redir", 32'h0000_000C, 1'b0, 1'b0, 1'b1);
      clearInputs(); instr = I_BEQ_M8;
      applyStimulus("bxx_taken", 32'h0000_0040, 1'b1, 1'b0, 1'b0);
      clearInputs(); setResolve(32'h40, 1'b0);
      applyStimulus("bxx_target", 32'h0000_0038, 1'b0, 1'b0, 1'b0);
      clearInputs(); setResolve(32'h40, 1'b0);
      applyStimulus("untrain_2", 32'h0000_003C, 1'b0, 1'b0, 1'b0);
      clearInputs(); instr = I_BEQ_M8; setResolve(32'h40, 1'b0);
      applyStimulus("bxx_weak_nt", 32'h0000_0040, 1'b0, 1'b0, 1'b0);
      clearInputs(); setResolve(32'h40, 1'b0); setFail(32'h40);
      applyStimulus("bxx_fallthru_sat0", 32'h0000_0044, 1'b0, 1'b0, 1'b1);
      clearInputs(); instr = I_BEQ_M8; setResolve(32'h40, 1'b1);
      applyStimulus("bxx_ctr00", 32'h0000_0040, 1'b0, 1'b0, 1'b0);
      clearInputs(); setFail(32'h40);
      applyStimulus("redir_back", 32'h0000_0044, 1'b0, 1'b0, 1'b1);
      clearInputs(); instr = I_BEQ_M8; stall = 1'b1; setResolve(32'h40, 1'b1);
      applyStimulus("same_idx_old", 32'h0000_0040, 1'b0, 1'b0, 1'b0);
      clearInputs(); instr = I_BEQ_M8;
      applyStimulus("same_idx_new", 32'h0000_0040, 1'b1, 1'b0, 1'b0);
      clearInputs(); setFail(32'h200);
      applyStimulus("to_call_site", 32'h0000_0038, 1'b0, 1'b0, 1'b1);

      clearInputs(); instr = I_JAL_RA;
      applyStimulus("call_0x200", 32'h0000_0200, 1'b0, 1'b0, 1'b0);
      clearInputs(); instr = I_RET;
      applyStimulus("ret_0x300", 32'h0000_0300, 1'b0, 1'b1, 1'b0);
      clearInputs();
      applyStimulus("ret_target", 32'h0000_0204, 1'b0, 1'b0, 1'b0);
      clearInputs(); instr = I_RET;
      applyStimulus("ret_empty", 32'h0000_0208, 1'b0, 1'b0, 1'b0);
      clearInputs(); setFail(32'h200);
      applyStimulus("ret_empty_seq", 32'h0000_020C, 1'b0, 1'b0, 1'b1);

      for (int k = 0; k < 5; k++) begin
         clearInputs(); instr = I_JAL_RA;
         applyStimulus($sformatf("call_%0d", k), 32'h200 + 32'h100 * k, 1'b0, 1'b0, 1'b0);
      end
      clearInputs(); instr = I_RET;
      applyStimulus("ret_0", 32'h0000_0700, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         clearInputs(); instr = I_RET;
         applyStimulus($sformatf("ret_%0d", k + 1), 32'h604 - 32'h100 * k, 1'b0, 1'b1, 1'b0);
      end
      clearInputs(); instr = I_RET;
      applyStimulus("ret_4_empty", 32'h0000_0304, 1'b0, 1'b0, 1'b0);
      clearInputs(); setFail(32'h200);
      applyStimulus("ret_4_seq", 32'h0000_0308, 1'b0, 1'b0, 1'b1);

      clearInputs(); instr = I_JAL_RA;
      applyStimulus("call_again", 32'h0000_0200, 1'b0, 1'b0, 1'b0);
      clearInputs(); instr = I_RET; stall = 1'b1; id_jalr = 1'b1;
      id_reg_value = 32'h900; setFail(32'h800);
      applyStimulus("all_redirects", 32'h0000_0300, 1'b0, 1'b0, 1'b1);
      clearInputs(); instr = I_JAL_RA; id_jalr = 1'b1; id_reg_value = 32'h1000;
      applyStimulus("jalr_over_call", 32'h0000_0800, 1'b0, 1'b0, 1'b1);
      clearInputs(); instr = I_JAL_RA; stall = 1'b1;
      applyStimulus("stall_over_call", 32'h0000_1000, 1'b0, 1'b0, 1'b0);
      clearInputs(); instr = I_RET;
      applyStimulus("ras_intact", 32'h0000_1000, 1'b0, 1'b1, 1'b0);
      clearInputs(); instr = I_BEQ_16;
      applyStimulus("bxx_fresh_idx", 32'h0000_0204, 1'b0, 1'b0, 1'b0);
      clearInputs(); setFail(32'hFFFF_FFFC);
      applyStimulus("bxx_fresh_seq", 32'h0000_0208, 1'b0, 1'b0, 1'b1);
      clearInputs();
      applyStimulus("wrap_top", 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
      clearInputs();
      applyStimulus("wrap_zero", 32'h0000_0000, 1'b0, 1'b0, 1'b0);
      clearInputs(); rst = 1'b1; setFail(32'h500);
      applyStimulus("rst_with_redir", 32'h0000_0004, 1'b0, 1'b0, 1'b1);
      clearInputs(); setFail(32'h40);
      applyStimulus("after_rst", 32'h0000_0000, 1'b0, 1'b0, 1'b1);
      clearInputs(); instr = I_BEQ_M8;
      applyStimulus("bht_reset_again", 32'h0000_0040, 1'b0, 1'b0, 1'b0);
      clearInputs();
      applyStimulus("post_reset_seq", 32'h0000_0044, 1'b0, 1'b0, 1'b0);

      @(posedge clk);
      #1;
      checks++;
      if (expQ.size() == 0) passed++;
      else $display("[TB] FAIL scoreboard_drain actual=%0d required=0", expQ.size());

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
